// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_pkg
//  Purpose  : Shared definitions for the round-robin mux arbiter: requester
//             count, index width, arbiter state type and a one-hot helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    // Number of requesters and the width of an index that selects one.
    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    // Arbiter states: no owner, or exactly one requester owns the output.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Expand a requester index into its one-hot request/grant position.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux4_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_sel
//  Purpose  : Purely combinational 4:1 data select for the arbiter output.
//  Ports    : sel        - index of the input to pass through
//             a, b, c, d - data inputs 0..3, W bits each
//             y          - selected data, W bits
//  Params   : W - data width
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_sel
    import mux_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [IDX_W-1:0] sel,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic [W-1:0]     y
);

    always_comb begin
        y = a;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = a;
        endcase
    end

endmodule : mux4_sel
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arbiter
//  Purpose  : Four-requester round-robin arbiter that steers the granted
//             requester's data onto a single output. Grants are registered
//             (one cycle after the request); data is passed combinationally.
//  Ports    : clk        - clock, all state changes on the rising edge
//             rst        - synchronous active-high reset
//             req[3:0]   - request per requester
//             a, b, c, d - requester data 0..3, W bits each
//             out_ready  - downstream accepts Out this cycle
//             gnt[3:0]   - one-hot grant, zero while idle
//             sel[1:0]   - index of the granted requester
//             out_valid  - Out carries the granted requester's data
//             Out        - selected data, forced to 0 while idle
//  Params   : W        - data width
//             MAX_HOLD - transfers allowed per grant before forced rotation
//  Macros   : MUX_ARB_TIMEOUT_EN - enables the hold counter and the forced
//             rotation after MAX_HOLD transfers; without it MAX_HOLD is unused
//  Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    input  logic             out_ready,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] sel,
    output logic             out_valid,
    output logic [W-1:0]     Out
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] w_sel_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;

    // Round-robin search results
    logic [NREQ-1:0]  w_mask;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_take;       // load a new owner at the next edge
    logic             w_hold_hit;   // owner used up its transfer allowance
    logic [W-1:0]     w_mux;

    // ------------------------------------------------------------------------
    // Round-robin search: first set bit of mask, scanning start, start+1, ...
    // modulo NREQ. Scanning from the far end and overwriting leaves the
    // closest match to start as the final answer. Returns {found, index}.
    // ------------------------------------------------------------------------
    function automatic logic [IDX_W:0] rr_search(
        input logic [NREQ-1:0]  mask,
        input logic [IDX_W-1:0] start
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W:0]   res;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = start + IDX_W'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // While granted, the current owner is removed from the candidate set.
    // If the owner has dropped its request its bit is already low, so the
    // same mask serves both re-arbitration and timeout rotation.
    always_comb begin
        w_mask = req;
        if (r_state == GRANT) begin
            w_mask = req & ~idx_to_onehot(r_sel);
        end
    end

    always_comb begin
        {w_found, w_win} = rr_search(w_mask, r_ptr);
    end

    // ------------------------------------------------------------------------
    // Optional hold counter: counts accepted transfers of the current owner.
    // The transfer that brings it to MAX_HOLD ends the owner's turn when any
    // other requester is waiting; with nobody waiting the count restarts.
    // ------------------------------------------------------------------------
`ifdef MUX_ARB_TIMEOUT_EN
    localparam int c_HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_inc;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_xfer;

    assign w_xfer = (r_state == GRANT) && out_ready;

    always_comb begin
        w_hold_inc = r_hold;
        if (w_xfer && (r_hold < c_HOLD_W'(MAX_HOLD))) begin
            w_hold_inc = r_hold + c_HOLD_W'(1);
        end
    end

    assign w_hold_hit = (r_state == GRANT) && (w_hold_inc >= c_HOLD_W'(MAX_HOLD));

    always_comb begin
        w_hold_nxt = r_hold;
        if (w_take || w_hold_hit) begin
            w_hold_nxt = '0;
        end else if (r_state == GRANT) begin
            w_hold_nxt = w_hold_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`else
    // No timeout: a grant ends only when its request drops. MAX_HOLD and
    // out_ready have no effect on the grant in this build.
    logic w_unused_nc;
    assign w_unused_nc = ^{out_ready, 32'(MAX_HOLD)};
    assign w_hold_hit  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_take      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take = 1'b1;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    // Owner released: hand over without an idle cycle, or
                    // fall back to idle when nobody else is asking.
                    if (w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_hold_hit && w_found) begin
                    // Allowance exhausted with others waiting: rotate.
                    w_take = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_take) begin
            w_state_nxt = GRANT;
            w_sel_nxt   = w_win;
            w_ptr_nxt   = w_win + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: grant decode is registered-state only; data is combinational.
    // ------------------------------------------------------------------------
    mux4_sel #(
        .W (W)
    ) u_mux4_sel (
        .sel (r_sel),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .y   (w_mux)
    );

    assign out_valid = (r_state == GRANT);
    assign sel       = r_sel;
    assign gnt       = out_valid ? idx_to_onehot(r_sel) : '0;
    assign Out       = out_valid ? w_mux : '0;

endmodule : mux_arbiter
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arbiter
//  Purpose  : Self-checking bench for mux_arbiter. A behavioural model of the
//             grant rules runs alongside the DUT and is compared every cycle;
//             directed sequences pin the model with literal expectations,
//             followed by a randomized phase.
//  Macros   : MUX_ARB_TIMEOUT_EN - selects the timeout expectations
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter;

    localparam int W        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] a, b, c, d;
    logic         out_ready;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] Out;

    int n_tests = 0;
    int n_fail  = 0;

    mux_arbiter #(
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .Out       (Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // First requester with a request, scanning from p upward modulo 4.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: owner / pointer / transfer count, advanced on each
    // rising edge from the inputs the DUT samples at that edge.
    // ------------------------------------------------------------------------
    bit m_init    = 1'b0;
    bit m_granted = 1'b0;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_hold    = 0;

    always @(posedge clk) begin : p_model
        bit         g;
        int         o, p, h, w;
        logic [3:0] oth;
        g = m_granted; o = m_owner; p = m_ptr; h = m_hold;
        oth = 4'd0;
        if (rst) begin
            g = 1'b0; o = 0; p = 0; h = 0;
        end else if (!g || !req[o]) begin
            w = rr_pick(req, p);
            if (w >= 0) begin
                g = 1'b1; o = w; p = (w + 1) % 4; h = 0;
            end else begin
                g = 1'b0;
            end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            h = h + (out_ready ? 1 : 0);
            if (h > MAX_HOLD) h = MAX_HOLD;
            if (h >= MAX_HOLD) begin
                oth    = req;
                oth[o] = 1'b0;
                w = rr_pick(oth, p);
                if (w >= 0) begin
                    o = w; p = (w + 1) % 4;
                end
                h = 0;
            end
`endif
        end
        if (rst) m_init <= 1'b1;
        m_granted <= g;
        m_owner   <= o;
        m_ptr     <= p;
        m_hold    <= h;
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin : p_compare
        logic [W-1:0] ed;
        ed = '0;
        if (m_init) begin
            if (m_granted) begin
                case (m_owner)
                    0: ed = a;
                    1: ed = b;
                    2: ed = c;
                    default: ed = d;
                endcase
            end
            chk("model gnt", int'(gnt), m_granted ? (1 << m_owner) : 0);
            chk("model out_valid", int'(out_valid), int'(m_granted));
            if (m_granted) chk("model sel", int'(sel), m_owner);
            chk("model Out", int'(Out), int'(ed));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Stimulus with literal checks
    // ------------------------------------------------------------------------
    initial begin : p_stim
        int seq[11];
        int cnt[4];
        int exp_seq[11];
        exp_seq = '{-1, 0, 0, 1, 1, 2, 2, 3, 3, -1, -1};

        rst = 1'b1; req = 4'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("reset gnt", int'(gnt), 0);
        chk("reset sel", int'(sel), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset Out", int'(Out), 0);

        // Single request from requester 1 with b=2
        req = 4'b0010; a = 4'd5; b = 4'd2; c = 4'd7; d = 4'd9;
        tick();
        @(negedge clk);
        chk("single gnt", int'(gnt), 2);
        chk("single sel", int'(sel), 1);
        chk("single out_valid", int'(out_valid), 1);
        chk("single Out", int'(Out), 2);
        b = 4'd11;
        #1;
        chk("comb Out follows b", int'(Out), 11);

        // Release -> idle, then all request: pointer is 2 so requester 2 wins
        req = 4'b0000;
        tick();
        @(negedge clk);
        chk("release out_valid", int'(out_valid), 0);
        chk("release gnt", int'(gnt), 0);
        req = 4'b1111;
        tick();
        @(negedge clk);
        chk("ptr2 sel", int'(sel), 2);
        chk("ptr2 Out", int'(Out), 7);

        // Reset during grant; req sampled during reset is ignored
        rst = 1'b1; req = 4'b0100;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort gnt", int'(gnt), 0);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort Out", int'(Out), 0);
        tick();
        @(negedge clk);
        chk("regrant gnt", int'(gnt), 4);

        // All request, each releases after two transfers: order 0,1,2,3
        pulse_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seq[i] = int'(sel);
                cnt[sel] = cnt[sel] + 1;
                if (cnt[sel] == 2) req[sel] = 1'b0;
            end else begin
                seq[i] = -1;
            end
        end
        for (int i = 0; i < 11; i++) chk($sformatf("rr order[%0d]", i), seq[i], exp_seq[i]);

        // Owner 3 releases while requester 0 waits: pointer wraps to 0
        pulse_reset();
        req = 4'b1000;
        tick();
        @(negedge clk);
        chk("wrap owner3 sel", int'(sel), 3);
        req = 4'b0001;
        tick();
        @(negedge clk);
        chk("wrap sel", int'(sel), 0);
        chk("wrap out_valid", int'(out_valid), 1);

        // Two persistent requesters
        pulse_reset();
        req = 4'b0011; out_ready = 1'b1;
        tick();
`ifdef MUX_ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            chk($sformatf("hold owner0 cyc%0d", i), int'(gnt), 1);
        end
        @(negedge clk);
        chk("timeout rotate", int'(gnt), 2);
        pulse_reset();
        req = 4'b0011; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("stalled hold cyc%0d", i), int'(gnt), 1);
        end
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("no timeout cyc%0d", i), int'(gnt), 1);
        end
`endif

        // Randomized phase, checked by the model every cycle
        @(posedge clk); #1;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 4) == 0) req[k] = ~req[k];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom);
            c = W'($urandom); d = W'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_arbiter
`default_nettype wire
